multiplexer: RTL and testbench

MULTIPLEXER -- requirements
Module: multiplexer

---
 rtl/multiplexer.sv | 88 ++++++++
 tb/tb_multiplexer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplexer.sv
// Two-way data mux with registered copy, valid strobe and choice-switch counter.
// Define MULTIPLEXER_PARITY_EN to add the registered parity bit of result_q.
module multiplexer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       option1,
  input  logic [WIDTH-1:0]       option2,
  input  logic                   choice,
  input  logic                   enable,
  output logic [WIDTH-1:0]       result,
  output logic [WIDTH-1:0]       result_q,
  output logic                   valid_q,
  output logic [COUNT_WIDTH-1:0] switch_count,
  output logic                   parity_q
);

  logic [WIDTH-1:0]       mux_w;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_d, vld_q;
  logic                   prev_q, prev_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   switched_w;

  assign mux_w  = choice ? option2 : option1;
  assign result = mux_w;

  assign switched_w = enable && (choice != prev_q);

  always_comb begin
    data_d  = data_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    valid_d = enable;
    if (enable) begin
      data_d = mux_w;
      prev_d = choice;
    end
    // Counter sticks at all-ones instead of wrapping.
    if (switched_w && (cnt_q != {COUNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= valid_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign result_q     = data_q;
  assign valid_q      = vld_q;
  assign switch_count = cnt_q;

`ifdef MULTIPLEXER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (enable) begin
      par_d = ^mux_w;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_q = par_q;
`else
  assign parity_q = 1'b0;
`endif

endmodule

// File: tb/tb_multiplexer.sv
// Directed bench for multiplexer: per-cycle reference model plus literal checks.
// A second instance with COUNT_WIDTH=2 exercises counter saturation.
module tb_multiplexer;

  logic        clock;
  logic        reset;
  logic [31:0] option1;
  logic [31:0] option2;
  logic        choice;
  logic        enable;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        valid_q;
  logic [15:0] switch_count;
  logic        parity_q;
  logic [31:0] s_result;
  logic [31:0] s_result_q;
  logic        s_valid_q;
  logic [1:0]  s_count;
  logic        s_parity_q;

  int checks = 0;
  int errors = 0;

  multiplexer #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .option1(option1), .option2(option2),
    .choice(choice), .enable(enable),
    .result(result), .result_q(result_q),
    .valid_q(valid_q), .switch_count(switch_count),
    .parity_q(parity_q)
  );

  multiplexer #(.WIDTH(32), .COUNT_WIDTH(2)) dut_s (
    .clock(clock), .reset(reset),
    .option1(option1), .option2(option2),
    .choice(choice), .enable(enable),
    .result(s_result), .result_q(s_result_q),
    .valid_q(s_valid_q), .switch_count(s_count),
    .parity_q(s_parity_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit par_of(input logic [31:0] v);
    int ones = 0;
    for (int i = 0; i < 32; i++) ones += int'(v[i]);
`ifdef MULTIPLEXER_PARITY_EN
    return (ones % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: what each output must hold after the last edge.
  logic [31:0] m_rq;
  bit          m_valid;
  bit          m_prev;
  int          m_cnt;
  int          m_scnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rq = 0; m_valid = 0; m_prev = 0; m_cnt = 0; m_scnt = 0;
    end else begin
      m_valid = enable;
      if (enable) begin
        if (choice != m_prev) begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (m_scnt < 3) m_scnt = m_scnt + 1;
        end
        m_prev = choice;
        m_rq = (choice == 1'b1) ? option2 : option1;
      end
    end
  end

  always @(negedge clock) begin
    logic [31:0] exp_res;
    exp_res = (choice == 1'b1) ? option2 : option1;
    chk("m_result", result, exp_res);
    chk("m_result_q", result_q, m_rq);
    chk("m_valid_q", 32'(valid_q), 32'(m_valid));
    chk("m_count", 32'(switch_count), 32'(m_cnt));
    chk("m_parity", 32'(parity_q), 32'(par_of(m_rq)));
    chk("m_s_result_q", s_result_q, m_rq);
    chk("m_s_count", 32'(s_count), 32'(m_scnt));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; choice = 1'b0;
    option1 = 32'h0; option2 = 32'h0;
    #1;
    chk("rst_result_q", result_q, 32'h0);
    chk("rst_valid_q", 32'(valid_q), 32'h0);
    chk("rst_count", 32'(switch_count), 32'h0);
    chk("rst_parity", 32'(parity_q), 32'h0);
    step(); step();
    reset = 1'b0;

    // combinational path, no captures
    option1 = 32'h0; option2 = 32'h87654321; choice = 1'b0;
    #1 chk("comb_c0", result, 32'h0);
    choice = 1'b1;
    #1 chk("comb_c1", result, 32'h87654321);

    // registered captures
    option2 = 32'h12345678; choice = 1'b0; enable = 1'b1;
    step();
    chk("cap0_rq", result_q, 32'h0);
    chk("cap0_valid", 32'(valid_q), 32'h1);
    chk("cap0_cnt", 32'(switch_count), 32'h0);
    choice = 1'b1;
    step();
    chk("cap1_rq", result_q, 32'h12345678);
    chk("cap1_valid", 32'(valid_q), 32'h1);
    chk("cap1_cnt", 32'(switch_count), 32'h1);

    // parity patterns
    option1 = 32'h11112222; option2 = 32'h0; choice = 1'b0;
    step();
    chk("par0_rq", result_q, 32'h11112222);
    chk("par0_bit", 32'(parity_q), 32'h0);
    chk("par0_cnt", 32'(switch_count), 32'h2);
    option2 = 32'h87654321; choice = 1'b1;
    step();
    chk("par1_rq", result_q, 32'h87654321);
`ifdef MULTIPLEXER_PARITY_EN
    chk("par1_bit", 32'(parity_q), 32'h1);
`else
    chk("par1_bit", 32'(parity_q), 32'h0);
`endif
    chk("par1_cnt", 32'(switch_count), 32'h3);

    // hold while disabled
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      choice = ~choice;
      option1 = option1 + 32'h1010;
      option2 = option2 ^ 32'hFFFF0000;
      step();
    end
    chk("hold_rq", result_q, 32'h87654321);
    chk("hold_cnt", 32'(switch_count), 32'h3);
    chk("hold_valid", 32'(valid_q), 32'h0);

    // saturation on the 2-bit counter; prev choice is 1
    enable = 1'b1;
    choice = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      choice = ~choice;
      step();
    end
    chk("sat_small", 32'(s_count), 32'h3);
    chk("sat_big", 32'(switch_count), 32'h8);

    // async reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_rq", result_q, 32'h0);
    chk("arst_valid", 32'(valid_q), 32'h0);
    chk("arst_cnt", 32'(switch_count), 32'h0);
    chk("arst_scnt", 32'(s_count), 32'h0);
    chk("arst_parity", 32'(parity_q), 32'h0);
    option1 = 32'hA5A5A5A5; choice = 1'b0;
    #1 chk("arst_result", result, 32'hA5A5A5A5);
    step();
    chk("arst_hold_rq", result_q, 32'h0);
    chk("arst_hold_valid", 32'(valid_q), 32'h0);
    reset = 1'b0;

    // first capture after reset: choice 1 vs cleared prev 0
    option2 = 32'hDEADBEEF; choice = 1'b1;
    step();
    chk("post_rq", result_q, 32'hDEADBEEF);
    chk("post_cnt", 32'(switch_count), 32'h1);
    enable = 1'b0;
    step();
    chk("post_valid", 32'(valid_q), 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
